// File: rtl/mem_access_unit.sv
// RV32I memory-stage load/store unit: formats loads, lane-aligns stores and
// runs a req/ready handshake with a variable-latency data memory.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] read_data,
  output logic        misalign,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q;
  logic [15:0] cnt_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        to_q;
  logic        req_q, we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q, wdata_q, rdata_q;

  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'b0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'b0001 << off;
      2'b01:   return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] w);
    case (f3[1:0])
      2'b00:   return {4{w[7:0]}};
      2'b01:   return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  logic op, illegal, misal, idle, issue;

  always_comb begin
    op      = mem_read | mem_write;
    illegal = mem_write ? (funct3[2] | (funct3[1:0] == 2'b11))
                        : ((funct3 == 3'b011) | (funct3[2:1] == 2'b11));
    misal   = ((funct3[1:0] == 2'b01) & addr[0]) |
              ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
    idle    = (state_q == IDLE);
    issue   = idle & op & !illegal & !misal;
  end

  // Faults raised in IDLE are same-cycle pulses; a timeout reports in DONE.
  assign stall      = issue | (state_q == BUSY);
  assign misalign   = idle & op & !illegal & misal;
  assign bus_err    = (idle & op & illegal) | ((state_q == DONE) & to_q);
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_be    = be_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign read_data  = rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      rdata_q <= 32'h0;
      cnt_q   <= 16'h0;
      to_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue) begin
            addr_q  <= {addr[31:2], 2'b00};
            we_q    <= mem_write;
            be_q    <= mem_write ? store_be(funct3, addr[1:0]) : 4'b1111;
            wdata_q <= store_data(funct3, wdata);
            f3_q    <= funct3;
            off_q   <= addr[1:0];
            req_q   <= 1'b1;
            cnt_q   <= 16'h0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (dmem_ready) begin
            req_q <= 1'b0;
            if (!we_q) rdata_q <= fmt_load(f3_q, off_q, dmem_rdata);
            state_q <= DONE;
          end else if (cnt_q == CNT_LAST) begin
            req_q <= 1'b0;
            if (!we_q) rdata_q <= 32'h0;
            to_q    <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + 16'h1;
          end
        end
        DONE: begin
          to_q    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, faults, timeout, reset.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall;
  logic [31:0] read_data;
  logic        misalign, bus_err;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  int total = 0;
  int bad   = 0;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
    .read_data(read_data), .misalign(misalign), .bus_err(bus_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one op, answer after 'waits' request cycles, stop in the DONE cycle
  // (or the same cycle for a rejected op). Captures first-request outputs.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input int waits,
                        input logic [31:0] rdat, output int stall_cyc, output int req_cyc,
                        output logic [31:0] o_addr, output logic [31:0] o_wdata,
                        output logic [3:0] o_be, output logic o_we);
    @(negedge clk);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    dmem_ready = 1'b0;
    stall_cyc = 0; req_cyc = 0;
    o_addr = 32'hx; o_wdata = 32'hx; o_be = 4'hx; o_we = 1'bx;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!stall) break;
      stall_cyc++;
      if (dmem_req) begin
        if (req_cyc == 0) begin
          o_addr = dmem_addr; o_wdata = dmem_wdata; o_be = dmem_be; o_we = dmem_we;
        end
        if (req_cyc == waits) begin
          dmem_ready = 1'b1; dmem_rdata = rdat;
        end
        req_cyc++;
      end
      @(negedge clk);
      dmem_ready = 1'b0;
    end
    check("op_completes", {31'b0, stall}, 32'h0);
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  int          sc, rc;
  logic [31:0] oa, ow;
  logic [3:0]  ob;
  logic        owe;

  initial begin
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000;
    addr = 32'h0; wdata = 32'h0; dmem_ready = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", {31'b0, stall}, 32'h0);
    check("rst_req", {31'b0, dmem_req}, 32'h0);
    check("rst_we_be", {27'b0, dmem_we, dmem_be}, 32'h0);
    check("rst_rdata", read_data, 32'h0);
    check("rst_faults", {30'b0, misalign, bus_err}, 32'h0);
    rst_n = 1'b1;

    run_op(1, 0, 3'b000, 32'h103, 32'h0, 2, 32'h80AB_CD12, sc, rc, oa, ow, ob, owe);
    check("lb_stall_cyc", sc, 4);
    check("lb_addr", oa, 32'h100);
    check("lb_be_we", {27'b0, owe, ob}, 32'h0F);
    check("lb_rdata", read_data, 32'hFFFF_FF80);
    check("lb_done_req", {31'b0, dmem_req}, 32'h0);

    run_op(1, 0, 3'b101, 32'h202, 32'h0, 0, 32'hF00D_1234, sc, rc, oa, ow, ob, owe);
    check("lhu_min_latency", sc, 2);
    check("lhu_rdata", read_data, 32'h0000_F00D);
    run_op(1, 0, 3'b100, 32'h201, 32'h0, 0, 32'hF00D_1234, sc, rc, oa, ow, ob, owe);
    check("lbu_rdata", read_data, 32'h0000_0012);
    run_op(1, 0, 3'b001, 32'h202, 32'h0, 1, 32'hF00D_1234, sc, rc, oa, ow, ob, owe);
    check("lh_rdata", read_data, 32'hFFFF_F00D);
    run_op(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEAD_BEEF, sc, rc, oa, ow, ob, owe);
    check("lw_rdata", read_data, 32'hDEAD_BEEF);

    run_op(0, 1, 3'b001, 32'h306, 32'h1234_ABCD, 1, 32'h5555_5555, sc, rc, oa, ow, ob, owe);
    check("sh_addr", oa, 32'h304);
    check("sh_be_we", {27'b0, owe, ob}, 32'h1C);
    check("sh_wdata", ow, 32'hABCD_ABCD);
    check("sh_rdata_kept", read_data, 32'hDEAD_BEEF);
    run_op(0, 1, 3'b000, 32'h301, 32'h0000_125A, 0, 32'h0, sc, rc, oa, ow, ob, owe);
    check("sb_be", {28'b0, ob}, 32'h2);
    check("sb_wdata", ow, 32'h5A5A_5A5A);
    run_op(1, 1, 3'b010, 32'h300, 32'hCAFE_F00D, 0, 32'h1111_1111, sc, rc, oa, ow, ob, owe);
    check("sw_prio_be_we", {27'b0, owe, ob}, 32'h1F);
    check("sw_wdata", ow, 32'hCAFE_F00D);
    check("sw_rdata_kept", read_data, 32'hDEAD_BEEF);

    run_op(1, 0, 3'b010, 32'h402, 32'h0, 0, 32'h0, sc, rc, oa, ow, ob, owe);
    check("misal_pulse", {30'b0, misalign, bus_err}, 32'h2);
    check("misal_no_req", sc + rc, 0);
    @(negedge clk); #1;
    check("misal_cleared", {30'b0, misalign, dmem_req}, 32'h0);
    run_op(0, 1, 3'b001, 32'h305, 32'h0, 0, 32'h0, sc, rc, oa, ow, ob, owe);
    check("sh_misal", {30'b0, misalign, dmem_req}, 32'h2);
    check("misal_rdata_kept", read_data, 32'hDEAD_BEEF);

    run_op(1, 0, 3'b011, 32'h400, 32'h0, 0, 32'h0, sc, rc, oa, ow, ob, owe);
    check("ld_illegal", {30'b0, misalign, bus_err}, 32'h1);
    run_op(0, 1, 3'b100, 32'h400, 32'h0, 0, 32'h0, sc, rc, oa, ow, ob, owe);
    check("st_illegal", {30'b0, dmem_req, bus_err}, 32'h1);
    check("illegal_no_stall", sc, 0);

    run_op(1, 0, 3'b010, 32'h500, 32'h0, 99, 32'h0, sc, rc, oa, ow, ob, owe);
    check("to_req_cyc", rc, 4);
    check("to_stall_cyc", sc, 5);
    check("to_bus_err", {31'b0, bus_err}, 32'h1);
    check("to_rdata", read_data, 32'h0);
    @(negedge clk); #1;
    check("to_err_pulse", {31'b0, bus_err}, 32'h0);

    run_op(1, 0, 3'b010, 32'h104, 32'h0, 0, 32'h2468_ACE0, sc, rc, oa, ow, ob, owe);
    check("pre_rst_rdata", read_data, 32'h2468_ACE0);
    @(negedge clk);
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h600;
    @(negedge clk); #1;
    check("mid_busy_req", {31'b0, dmem_req}, 32'h1);
    rst_n = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; #1;
    check("mid_rst_idle", {29'b0, dmem_req, stall, misalign}, 32'h0);
    check("mid_rst_rdata", read_data, 32'h0);
    run_op(1, 0, 3'b010, 32'h600, 32'h0, 1, 32'h1357_9BDF, sc, rc, oa, ow, ob, owe);
    check("post_rst_lw", read_data, 32'h1357_9BDF);
    check("post_rst_addr", oa, 32'h600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store unit of the RV32I core.
- Sits between the EX-stage outputs (addr = ALU result, store data, mem_read/mem_write, funct3) and the data memory port.
- Produces the formatted, sign- or zero-extended read_data that feeds the write-back select.
- Runs a request/ready handshake with a variable-latency data memory and stalls the core until each access completes.

Parameters:
TIMEOUT, 255, max BUSY cycles waiting for dmem_ready before the access is aborted with a bus error (range 1..65535)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, synchronous, active-low
mem_read  input  1  current instruction is a load
mem_write  input  1  current instruction is a store (takes priority if both are set)
funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
addr  input  32  byte address from the ALU
wdata  input  32  store data (rs2)
stall  output  1  freeze PC and pipeline registers
read_data  output  32  formatted load result
misalign  output  1  one-cycle pulse: misaligned access rejected
bus_err  output  1  one-cycle pulse: illegal funct3 or timeout
dmem_req  output  1  memory request, held until dmem_ready
dmem_we  output  1  1 = write
dmem_addr  output  32  word address {addr[31:2],2'b00}
dmem_be  output  4  byte enables
dmem_wdata  output  32  lane-aligned store data
dmem_ready  input  1  memory accepts/completes the request this cycle
dmem_rdata  input  32  read word, valid when dmem_ready=1

Behaviour:
- Reset (sync, rst_n=0 at a clock edge):
  - state=IDLE; dmem_req, dmem_we, dmem_be, misalign and bus_err = 0; read_data=0; timeout counter=0.
  - An outstanding request is dropped immediately. The memory must tolerate dmem_req falling without ready.
- States: IDLE, BUSY, DONE.
- IDLE, op = mem_read|mem_write:
  - Legal and aligned access:
    - stall=1 combinationally.
    - At the edge, register dmem_addr/be/wdata/we, set dmem_req=1, clear the counter, go to BUSY.
  - Misaligned access (H with addr[0]=1, W with addr[1:0]!=0):
    - No request; stall=0; misalign=1 for this cycle only; read_data unchanged; stay in IDLE.
  - Illegal funct3 (loads 011/110/111; stores other than 000/001/010):
    - No request; stall=0; bus_err=1 for this cycle; stay in IDLE.
- BUSY:
  - stall=1; dmem_req=1; all dmem_* outputs held stable.
  - dmem_ready=1 → dmem_req=0 next cycle. For a load, capture the formatted dmem_rdata into read_data. Go to DONE.
  - No ready and counter==TIMEOUT-1 → drop req, read_data=0 for a load, bus_err pulses in DONE.
  - Otherwise increment the counter.
- DONE:
  - stall=0 for exactly one cycle, so the core advances; go to IDLE unconditionally.
  - A new op is never accepted in DONE, which prevents a double issue of the same instruction.
- Minimum latency: 3 cycles (IDLE stall → BUSY with same-cycle ready → DONE).
- Load formatting (byte lane b=addr[1:0], half lane h=addr[1]):
  - LB/LBU: byte b, sign-/zero-extended.
  - LH/LHU: half h, sign-/zero-extended.
  - LW: full word.
- Stores:
  - SB: be=4'b0001<<b; wdata[7:0] replicated to all 4 lanes.
  - SH: be=h?1100:0011; wdata[15:0] replicated to both halves.
  - SW: be=1111.
- read_data changes only on load completion or reset; stores and faults never alter it.
- Loads drive dmem_be=1111 and dmem_we=0.

Test Plan:
- Load byte: LB at addr 0x103, memory returns 0x80AB_CD12 after 2 wait cycles → read_data=0xFFFF_FF80; stall high for 4 cycles; dmem_addr=0x100.
- Unsigned loads: LHU at addr 0x202 with rdata 0xF00D_1234 → read_data=0x0000_F00D. LBU at 0x201 → 0x0000_0012.
- Store half: SH at addr 0x306 with wdata 0x1234_ABCD → dmem_be=1100, dmem_wdata=0xABCD_ABCD, dmem_we=1; read_data unchanged.
- Misalign: LW at 0x402 → misalign=1 for 1 cycle, stall=0, dmem_req never asserted.
- Timeout: TIMEOUT=4, dmem_ready tied 0 → req high 4 cycles, then DONE with bus_err=1, read_data=0, stall released.
- Reset mid-BUSY: rst_n=0 for 1 edge while dmem_req=1 → next cycle state IDLE, dmem_req=0, read_data=0, stall=0; a following LW completes normally.
